fir_mac_sequencer: RTL and testbench

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer.sv | 143 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR: one signed multiplier and one accumulator walk all taps per sample.
// Define FIR_COEF_LOAD_EN to add the runtime coefficient write port.
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes allowed
//   MAC   | one tap per cycle into the accumulator
//   OUT   | result presented until downstream accepts
module fir_mac_sequencer #(
    parameter int NTAPS = 19,
    parameter int DW    = 16,
    parameter int OW    = 34
) (
    input  logic                 aclk,
    input  logic                 areset,
`ifdef FIR_COEF_LOAD_EN
    input  logic                 coef_wr_en,
    input  logic [4:0]           coef_wr_addr,
    input  logic [DW-1:0]        coef_wr_data,
`endif
    input  logic                 s_axis_data_tvalid,
    output logic                 s_axis_data_tready,
    input  logic [DW-1:0]        s_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready,
    output logic [OW-1:0]        m_axis_data_tdata,
    output logic                 busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4:0]            r_wr_ptr;
    logic [4:0]            r_k;
    logic signed [DW-1:0]  r_buf [NTAPS];
    logic signed [OW-1:0]  r_acc;
    logic [4:0]            w_rd_idx;
    logic signed [DW-1:0]  w_coef_k;
    logic signed [DW-1:0]  w_samp_k;
    logic signed [2*DW-1:0] w_prod;
    logic signed [OW-1:0]  w_prod_ext;
    logic                  w_last_tap;

    function automatic int coef_init(input int idx);
        case (idx)
            0, 18:   return 26;
            1, 17:   return 270;
            2, 16:   return 963;
            3, 15:   return 2424;
            4, 14:   return 4869;
            5, 13:   return 8259;
            6, 12:   return 12194;
            7, 11:   return 15948;
            8, 10:   return 18666;
            9:       return 19660;
            default: return 0;
        endcase
    endfunction

    // Newest sample sits at r_wr_ptr until MAC ends; the 5-bit wrap keeps the
    // modular subtraction exact for any NTAPS up to 32.
    assign w_rd_idx   = (r_wr_ptr >= r_k) ? (r_wr_ptr - r_k)
                                          : (r_wr_ptr + 5'(NTAPS) - r_k);
    assign w_samp_k   = r_buf[w_rd_idx];
    assign w_prod     = w_coef_k * w_samp_k;
    assign w_prod_ext = {{(OW-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_last_tap = (r_k == 5'(NTAPS-1));

`ifdef FIR_COEF_LOAD_EN
    logic signed [DW-1:0] r_coef [32];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < 32; i++) r_coef[i] <= DW'(coef_init(i));
        end else if (coef_wr_en && (r_state == ST_IDLE) &&
                     ({1'b0, coef_wr_addr} < 6'(NTAPS))) begin
            r_coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    assign w_coef_k = r_coef[r_k];
`else
    always_comb begin
        w_coef_k = DW'(coef_init(int'(r_k)));
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt        = r_state;
        s_axis_data_tready = 1'b0;
        m_axis_data_tvalid = 1'b0;
        m_axis_data_tdata  = '0;
        busy               = 1'b1;
        case (r_state)
            ST_IDLE: begin
                s_axis_data_tready = 1'b1;
                busy               = 1'b0;
                if (s_axis_data_tvalid) w_state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (w_last_tap) w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                m_axis_data_tvalid = 1'b1;
                m_axis_data_tdata  = r_acc;
                if (m_axis_data_tready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_acc    <= '0;
            r_k      <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < NTAPS; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axis_data_tvalid) begin
                        r_buf[r_wr_ptr] <= s_axis_data_tdata;
                        r_acc           <= '0;
                        r_k             <= '0;
                    end
                end
                ST_MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    if (w_last_tap)
                        r_wr_ptr <= (r_wr_ptr == 5'(NTAPS-1)) ? 5'd0 : r_wr_ptr + 5'd1;
                    else
                        r_k <= r_k + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer against a sample-history convolution model.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 19;
    localparam int DW    = 16;
    localparam int OW    = 34;

    logic                 aclk = 1'b0;
    logic                 areset = 1'b1;
    logic                 s_axis_data_tvalid = 1'b0;
    logic                 s_axis_data_tready;
    logic signed [DW-1:0] s_axis_data_tdata = '0;
    logic                 m_axis_data_tvalid;
    logic                 m_axis_data_tready = 1'b1;
    logic signed [OW-1:0] m_axis_data_tdata;
    logic                 busy;
`ifdef FIR_COEF_LOAD_EN
    logic                 coef_wr_en = 1'b0;
    logic [4:0]           coef_wr_addr = '0;
    logic [DW-1:0]        coef_wr_data = '0;
`endif

    fir_mac_sequencer #(.NTAPS(NTAPS), .DW(DW), .OW(OW)) dut (
        .aclk               (aclk),
        .areset             (areset),
`ifdef FIR_COEF_LOAD_EN
        .coef_wr_en         (coef_wr_en),
        .coef_wr_addr       (coef_wr_addr),
        .coef_wr_data       (coef_wr_data),
`endif
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tready (m_axis_data_tready),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .busy               (busy)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;
    int ref_coef [NTAPS];
    int hist [$];

    function automatic void model_reset();
        hist.delete();
        ref_coef = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660,
                     18666, 15948, 12194, 8259, 4869, 2424, 963, 270, 26};
    endfunction

    function automatic void model_push(input int s);
        hist.push_front(s);
        if (hist.size() > NTAPS) void'(hist.pop_back());
    endfunction

    function automatic logic signed [OW-1:0] model_out();
        longint acc = 0;
        for (int k = 0; k < hist.size(); k++)
            acc += longint'(ref_coef[k]) * longint'(hist[k]);
        return OW'(acc);
    endfunction

    task automatic do_reset();
        areset = 1'b1;
        s_axis_data_tvalid = 1'b0;
        m_axis_data_tready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
        coef_wr_en = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        model_reset();
        @(posedge aclk);
        #1;
    endtask

    // Offers one sample, follows it to the output and completes the result handshake.
    task automatic drive_sample(input logic signed [DW-1:0] d, input int hold,
                                input bit noisy, input bit mac_wr,
                                output logic signed [OW-1:0] res, output int lat,
                                output bit tready_low_ok, output bit hold_ok,
                                output time t_acc);
        int guard = 0;
        s_axis_data_tdata  = d;
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = (hold == 0);
        while (!s_axis_data_tready && guard < 100) begin
            @(posedge aclk); #1; guard++;
        end
        @(posedge aclk);
        t_acc = $time;
        #1;
        s_axis_data_tvalid = 1'b0;
`ifdef FIR_COEF_LOAD_EN
        coef_wr_en = 1'b0;
`endif
        lat = 0;
        tready_low_ok = 1'b1;
        while (!m_axis_data_tvalid && lat < 200) begin
            if (s_axis_data_tready) tready_low_ok = 1'b0;
            if (noisy) begin
                s_axis_data_tvalid = 1'b1;
                s_axis_data_tdata  = DW'($urandom);
            end
`ifdef FIR_COEF_LOAD_EN
            if (mac_wr) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = 5'd1;
                coef_wr_data = 16'd555;
            end
`else
            if (mac_wr) lat = lat;
`endif
            @(posedge aclk); #1; lat++;
        end
        s_axis_data_tvalid = 1'b0;
`ifdef FIR_COEF_LOAD_EN
        coef_wr_en = 1'b0;
`endif
        res = m_axis_data_tdata;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            if (!m_axis_data_tvalid || m_axis_data_tdata !== res || s_axis_data_tready)
                hold_ok = 1'b0;
        end
        m_axis_data_tready = 1'b1;
        @(posedge aclk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (s_axis_data_tready !== 1'b1) begin n_err++; $display("FAIL reset_s_tready: got %b expected 1", s_axis_data_tready); end
        n_vec++; if (m_axis_data_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_m_tvalid: got %b expected 0", m_axis_data_tvalid); end
        n_vec++; if (m_axis_data_tdata !== '0) begin n_err++; $display("FAIL reset_m_tdata: got %0d expected 0", m_axis_data_tdata); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_impulse();
        logic signed [OW-1:0] res, exp_v;
        int lat; bit tr_ok, h_ok; time t;
        do_reset();
        for (int i = 0; i < NTAPS; i++) begin
            drive_sample((i == 0) ? 16'sd1 : 16'sd0, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
            model_push((i == 0) ? 1 : 0);
            exp_v = model_out();
            n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL impulse[%0d]: got %0d expected %0d", i, res, exp_v); end
            n_vec++; if (lat !== NTAPS) begin n_err++; $display("FAIL impulse_latency[%0d]: got %0d expected %0d", i, lat, NTAPS); end
            n_vec++; if (!tr_ok) begin n_err++; $display("FAIL impulse_tready_in_mac[%0d]: got 1 expected 0", i); end
        end
    endtask

    task automatic test_dc();
        logic signed [OW-1:0] res, exp_v;
        int lat; bit tr_ok, h_ok; time t;
        do_reset();
        for (int i = 0; i < NTAPS; i++) begin
            drive_sample(16'sd1, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
            model_push(1);
            exp_v = model_out();
            n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL dc[%0d]: got %0d expected %0d", i, res, exp_v); end
        end
        n_vec++; if (res !== 34'sd146898) begin n_err++; $display("FAIL dc_final: got %0d expected 146898", res); end
    endtask

    task automatic test_negative();
        logic signed [OW-1:0] res;
        int lat; bit tr_ok, h_ok; time t;
        do_reset();
        drive_sample(-16'sd32768, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        n_vec++; if (res !== -34'sd851968) begin n_err++; $display("FAIL negative: got %0d expected -851968", res); end
    endtask

    task automatic test_backpressure();
        logic signed [OW-1:0] res, exp_v;
        logic signed [DW-1:0] d;
        int lat; bit tr_ok, h_ok; time t;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            d = DW'($urandom);
            drive_sample(d, (i == 0) ? 10 : 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
            model_push(int'(d));
            exp_v = model_out();
            n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL backpressure[%0d]: got %0d expected %0d", i, res, exp_v); end
        end
        drive_sample(16'sd3, 10, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        model_push(3);
        exp_v = model_out();
        n_vec++; if (!h_ok) begin n_err++; $display("FAIL backpressure_hold: got unstable expected stable"); end
        n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL backpressure_held: got %0d expected %0d", res, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic signed [OW-1:0] res, exp_v;
        logic signed [DW-1:0] d;
        int lat; bit tr_ok, h_ok; time t, t_prev;
        do_reset();
        t_prev = 0;
        for (int i = 0; i < 25; i++) begin
            d = DW'($urandom);
            drive_sample(d, 0, 1'b1, 1'b0, res, lat, tr_ok, h_ok, t);
            model_push(int'(d));
            exp_v = model_out();
            n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL random[%0d]: got %0d expected %0d", i, res, exp_v); end
            n_vec++; if (!tr_ok) begin n_err++; $display("FAIL random_tready_in_mac[%0d]: got 1 expected 0", i); end
            if (i > 0) begin
                n_vec++;
                if ((t - t_prev) !== 64'(10 * (NTAPS + 2))) begin
                    n_err++; $display("FAIL throughput[%0d]: got %0t expected %0d", i, t - t_prev, 10 * (NTAPS + 2));
                end
            end
            t_prev = t;
        end
    endtask

    task automatic test_reset_mid_mac();
        logic signed [OW-1:0] res;
        int lat; bit tr_ok, h_ok, seen; time t;
        do_reset();
        s_axis_data_tdata  = 16'sd1;
        s_axis_data_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_axis_data_tvalid = 1'b0;
        repeat (7) @(posedge aclk);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midmac_busy: got %b expected 1", busy); end
        areset = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || m_axis_data_tvalid !== 1'b0) begin n_err++; $display("FAIL midmac_async: got busy=%b tvalid=%b expected 0 0", busy, m_axis_data_tvalid); end
        @(posedge aclk); #1;
        areset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge aclk); #1;
            if (m_axis_data_tvalid) seen = 1'b1;
        end
        n_vec++; if (seen) begin n_err++; $display("FAIL midmac_no_output: got tvalid=1 expected 0"); end
        drive_sample(16'sd1, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        n_vec++; if (res !== 34'sd26) begin n_err++; $display("FAIL midmac_next_impulse: got %0d expected 26", res); end
    endtask

`ifdef FIR_COEF_LOAD_EN
    task automatic test_coef_load();
        logic signed [OW-1:0] res, exp_v;
        int lat; bit tr_ok, h_ok; time t;
        do_reset();
        coef_wr_en = 1'b1; coef_wr_addr = 5'd0; coef_wr_data = 16'd100;
        @(posedge aclk); #1;
        coef_wr_en = 1'b0;
        ref_coef[0] = 100;
        drive_sample(16'sd1, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        model_push(1);
        n_vec++; if (res !== 34'sd100) begin n_err++; $display("FAIL coef_load: got %0d expected 100", res); end
        drive_sample(16'sd0, 0, 1'b0, 1'b1, res, lat, tr_ok, h_ok, t);
        model_push(0);
        drive_sample(16'sd0, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        model_push(0);
        exp_v = model_out();
        n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL coef_mac_write_dropped: got %0d expected %0d", res, exp_v); end
        coef_wr_en = 1'b1; coef_wr_addr = 5'd0; coef_wr_data = 16'hFFF9;
        ref_coef[0] = -7;
        drive_sample(16'sd2, 0, 1'b0, 1'b0, res, lat, tr_ok, h_ok, t);
        model_push(2);
        exp_v = model_out();
        n_vec++; if (res !== exp_v) begin n_err++; $display("FAIL coef_same_edge: got %0d expected %0d", res, exp_v); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_negative();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mac();
`ifdef FIR_COEF_LOAD_EN
        test_coef_load();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
